// File: rtl/rf_write_queue_pkg.sv
// Shared register-file definitions for the write-side queue: architectural
// register-address and data widths, the hard-wired zero register, and the
// writeback entry layout.
package rf_write_queue_pkg;

  localparam int REG_AW = 5;
  localparam int XLEN   = 32;

  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;

endpackage

// File: rtl/rf_write_queue_fwd_match.sv
// Youngest-match search over the queued writeback entries. Walks the slots
// from oldest to youngest relative to the write pointer, so the last match
// seen is the one nearest the write pointer. Register zero never hits.
module rf_fwd_match #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]         valid_i,
  input  logic [DEPTH-1:0][AW-1:0] rd_i,
  input  logic [DEPTH-1:0][DW-1:0] data_i,
  input  logic [PW-1:0]            wr_ptr_i,
  input  logic [AW-1:0]            addr_i,
  output logic                     hit_o,
  output logic [DW-1:0]            data_o
);

  logic [PW-1:0] idx;

  // Oldest-to-youngest scan; later matches override earlier ones.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      idx = wr_ptr_i - PW'(k);
      if (valid_i[idx] && (rd_i[idx] == addr_i) && (addr_i != '0)) begin
        hit_o  = 1'b1;
        data_o = data_i[idx];
      end
    end
  end

endmodule

// File: rtl/rf_write_queue.sv
// Write-side front end of the register file. Merges load-path and
// execute-path writebacks into an in-order queue, drains one entry per cycle
// into the file's single write port, and exposes forwarding hits for rs1/rs2
// against entries that are queued but not yet written.
module rf_write_queue
  import rf_write_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = REG_AW,
  parameter int DW    = XLEN
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_valid,
  input  logic [AW-1:0] ld_rd,
  input  logic [DW-1:0] ld_data,
  output logic          ld_ready,
  input  logic          ex_valid,
  input  logic [AW-1:0] ex_rd,
  input  logic [DW-1:0] ex_data,
  output logic          ex_ready,
  output logic          rf_wren,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  input  logic [AW-1:0] chk_addr1,
  input  logic [AW-1:0] chk_addr2,
  output logic          chk_hit1,
  output logic          chk_hit2,
  output logic [DW-1:0] chk_data1,
  output logic [DW-1:0] chk_data2,
  output logic          full,
  output logic          empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
  localparam logic [CW-1:0] DEPTH_M2_C = CW'(DEPTH - 2);

  logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]            count_q, count_d;
  logic [DEPTH-1:0]         valid_q, valid_d;
  logic [DEPTH-1:0][AW-1:0] rd_q;
  logic [DEPTH-1:0][DW-1:0] data_q;

  logic          ld_enq, ex_enq, pop;
  logic [PW-1:0] ex_slot;

  // Readiness looks only at the registered count: a same-cycle pop never
  // frees a slot for a same-cycle push, and when both paths request the
  // execute entry needs room behind the load entry.
  assign ld_ready = (count_q != DEPTH_C);
  assign ex_ready = ld_valid ? (count_q <= DEPTH_M2_C) : (count_q != DEPTH_C);

  // Writes to register zero complete the handshake but are dropped here.
  assign ld_enq  = ld_valid && ld_ready && (ld_rd != AW'(REG_ZERO));
  assign ex_enq  = ex_valid && ex_ready && (ex_rd != AW'(REG_ZERO));
  assign ex_slot = wr_ptr_q + PW'(ld_enq);

  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_C);
  assign pop   = !empty;

  assign rf_wren  = !empty;
  assign rf_waddr = rd_q[rd_ptr_q];
  assign rf_wdata = data_q[rd_ptr_q];

  assign rd_ptr_d = rd_ptr_q + PW'(pop);
  assign wr_ptr_d = wr_ptr_q + PW'(ld_enq) + PW'(ex_enq);
  assign count_d  = count_q + CW'(ld_enq) + CW'(ex_enq) - CW'(pop);

  // Per-slot valid bits: clear the popped head, set the slots being filled.
  always_comb begin
    valid_d = valid_q;
    if (pop)    valid_d[rd_ptr_q] = 1'b0;
    if (ld_enq) valid_d[wr_ptr_q] = 1'b1;
    if (ex_enq) valid_d[ex_slot]  = 1'b1;
  end

  // Queue control state; reset discards every queued entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  // Entry payload storage; the load entry lands first, execute behind it.
  always_ff @(posedge clk) begin
    if (ld_enq) begin
      rd_q[wr_ptr_q]   <= ld_rd;
      data_q[wr_ptr_q] <= ld_data;
    end
    if (ex_enq) begin
      rd_q[ex_slot]   <= ex_rd;
      data_q[ex_slot] <= ex_data;
    end
  end

  rf_fwd_match #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW),
    .PW    (PW)
  ) u_fwd_rs1 (
    .valid_i  (valid_q),
    .rd_i     (rd_q),
    .data_i   (data_q),
    .wr_ptr_i (wr_ptr_q),
    .addr_i   (chk_addr1),
    .hit_o    (chk_hit1),
    .data_o   (chk_data1)
  );

  rf_fwd_match #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW),
    .PW    (PW)
  ) u_fwd_rs2 (
    .valid_i  (valid_q),
    .rd_i     (rd_q),
    .data_i   (data_q),
    .wr_ptr_i (wr_ptr_q),
    .addr_i   (chk_addr2),
    .hit_o    (chk_hit2),
    .data_o   (chk_data2)
  );

endmodule

// File: tb/tb_rf_write_queue.sv
// Directed bench for rf_write_queue: a per-cycle vector table with
// hand-computed expectations plus reset sequences around it.
module tb_rf_write_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_valid, ex_valid;
  logic [4:0]  ld_rd, ex_rd, chk_addr1, chk_addr2;
  logic [31:0] ld_data, ex_data;
  logic        ld_ready, ex_ready, rf_wren, chk_hit1, chk_hit2, full, empty;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, chk_data1, chk_data2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rf_write_queue #(.DEPTH(4), .AW(5), .DW(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .ld_valid  (ld_valid),
    .ld_rd     (ld_rd),
    .ld_data   (ld_data),
    .ld_ready  (ld_ready),
    .ex_valid  (ex_valid),
    .ex_rd     (ex_rd),
    .ex_data   (ex_data),
    .ex_ready  (ex_ready),
    .rf_wren   (rf_wren),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .chk_addr1 (chk_addr1),
    .chk_addr2 (chk_addr2),
    .chk_hit1  (chk_hit1),
    .chk_hit2  (chk_hit2),
    .chk_data1 (chk_data1),
    .chk_data2 (chk_data2),
    .full      (full),
    .empty     (empty)
  );

  typedef struct {
    logic        ldv;
    logic [4:0]  ldrd;
    logic [31:0] lddat;
    logic        exv;
    logic [4:0]  exrd;
    logic [31:0] exdat;
    logic [4:0]  c1;
    logic [4:0]  c2;
    logic        e_ldr;
    logic        e_exr;
    logic        e_wren;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;
    logic        e_hit1;
    logic [31:0] e_d1;
    logic        e_hit2;
    logic [31:0] e_d2;
    logic        e_empty;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs[NV];

  function automatic vec_t mk(
    logic ldv, logic [4:0] ldrd, logic [31:0] lddat,
    logic exv, logic [4:0] exrd, logic [31:0] exdat,
    logic [4:0] c1, logic [4:0] c2,
    logic e_ldr, logic e_exr, logic e_wren, logic [4:0] e_waddr, logic [31:0] e_wdata,
    logic e_hit1, logic [31:0] e_d1, logic e_hit2, logic [31:0] e_d2, logic e_empty);
    vec_t v;
    v.ldv = ldv;  v.ldrd = ldrd;  v.lddat = lddat;
    v.exv = exv;  v.exrd = exrd;  v.exdat = exdat;
    v.c1 = c1;    v.c2 = c2;
    v.e_ldr = e_ldr;   v.e_exr = e_exr;
    v.e_wren = e_wren; v.e_waddr = e_waddr; v.e_wdata = e_wdata;
    v.e_hit1 = e_hit1; v.e_d1 = e_d1;
    v.e_hit2 = e_hit2; v.e_d2 = e_d2;
    v.e_empty = e_empty;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    ld_valid = 1'b0; ld_rd = 5'd0; ld_data = 32'd0;
    ex_valid = 1'b0; ex_rd = 5'd0; ex_data = 32'd0;
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Rows: inputs for the cycle, then outputs expected in that same cycle
    // (state reflects only pushes made at earlier edges).
    //            ldv rd     data          exv rd     data          c1     c2     ldr  exr  wren waddr  wdata         h1  d1            h2  d2            empty
    vecs[0]  = mk(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0,        5'd5,  5'd0,  1, 1, 0, 5'd0, 32'h0,        0, 32'h0,        0, 32'h0,  1);
    vecs[1]  = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        5'd5,  5'd0,  1, 1, 1, 5'd5, 32'hDEADBEEF, 1, 32'hDEADBEEF, 0, 32'h0,  0);
    vecs[2]  = mk(1, 5'd3, 32'h11,       1, 5'd3, 32'h22,       5'd3,  5'd0,  1, 1, 0, 5'd0, 32'h0,        0, 32'h0,        0, 32'h0,  1);
    vecs[3]  = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        5'd3,  5'd7,  1, 1, 1, 5'd3, 32'h11,       1, 32'h22,       0, 32'h0,  0);
    vecs[4]  = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        5'd3,  5'd0,  1, 1, 1, 5'd3, 32'h22,       1, 32'h22,       0, 32'h0,  0);
    vecs[5]  = mk(0, 5'd0, 32'h0,        1, 5'd0, 32'hFFFFFFFF, 5'd0,  5'd0,  1, 1, 0, 5'd0, 32'h0,        0, 32'h0,        0, 32'h0,  1);
    vecs[6]  = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        5'd0,  5'd0,  1, 1, 0, 5'd0, 32'h0,        0, 32'h0,        0, 32'h0,  1);
    vecs[7]  = mk(1, 5'd1, 32'hA1,       1, 5'd2, 32'hA2,       5'd1,  5'd2,  1, 1, 0, 5'd0, 32'h0,        0, 32'h0,        0, 32'h0,  1);
    vecs[8]  = mk(1, 5'd4, 32'hA4,       1, 5'd6, 32'hA6,       5'd1,  5'd2,  1, 1, 1, 5'd1, 32'hA1,       1, 32'hA1,       1, 32'hA2, 0);
    vecs[9]  = mk(1, 5'd7, 32'hA7,       1, 5'd8, 32'hA8,       5'd2,  5'd6,  1, 0, 1, 5'd2, 32'hA2,       1, 32'hA2,       1, 32'hA6, 0);
    vecs[10] = mk(0, 5'd0, 32'h0,        1, 5'd8, 32'hA8,       5'd7,  5'd8,  1, 1, 1, 5'd4, 32'hA4,       1, 32'hA7,       0, 32'h0,  0);
    vecs[11] = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        5'd6,  5'd8,  1, 1, 1, 5'd6, 32'hA6,       1, 32'hA6,       1, 32'hA8, 0);
    vecs[12] = mk(1, 5'd8, 32'hB8,       0, 5'd0, 32'h0,        5'd7,  5'd8,  1, 1, 1, 5'd7, 32'hA7,       1, 32'hA7,       1, 32'hA8, 0);
    vecs[13] = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        5'd7,  5'd8,  1, 1, 1, 5'd8, 32'hA8,       0, 32'h0,        1, 32'hB8, 0);
    vecs[14] = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        5'd0,  5'd8,  1, 1, 1, 5'd8, 32'hB8,       0, 32'h0,        1, 32'hB8, 0);
    vecs[15] = mk(1, 5'd0, 32'hC0,       1, 5'd9, 32'hC9,       5'd9,  5'd8,  1, 1, 0, 5'd0, 32'h0,        0, 32'h0,        0, 32'h0,  1);
    vecs[16] = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        5'd9,  5'd0,  1, 1, 1, 5'd9, 32'hC9,       1, 32'hC9,       0, 32'h0,  0);
    vecs[17] = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        5'd9,  5'd0,  1, 1, 0, 5'd0, 32'h0,        0, 32'h0,        0, 32'h0,  1);

    // Reset held with a request pending: nothing may be written or queued.
    rst = 1'b0;
    idle_inputs();
    ld_valid = 1'b1; ld_rd = 5'd5; ld_data = 32'h12345678;
    chk_addr1 = 5'd5; chk_addr2 = 5'd0;
    step();
    step();
    chk("rst wren", 32'(rf_wren), 32'd0);
    chk("rst empty", 32'(empty), 32'd1);
    chk("rst full", 32'(full), 32'd0);
    chk("rst hit1", 32'(chk_hit1), 32'd0);
    chk("rst ld_ready", 32'(ld_ready), 32'd1);
    chk("rst ex_ready", 32'(ex_ready), 32'd1);
    idle_inputs();
    rst = 1'b1;
    step();
    chk("post-rst wren", 32'(rf_wren), 32'd0);
    chk("post-rst empty", 32'(empty), 32'd1);

    // Table-driven cycles.
    for (int i = 0; i < NV; i++) begin
      ld_valid = vecs[i].ldv;  ld_rd = vecs[i].ldrd;  ld_data = vecs[i].lddat;
      ex_valid = vecs[i].exv;  ex_rd = vecs[i].exrd;  ex_data = vecs[i].exdat;
      chk_addr1 = vecs[i].c1;  chk_addr2 = vecs[i].c2;
      #1;
      chk($sformatf("row%0d ld_ready", i), 32'(ld_ready), 32'(vecs[i].e_ldr));
      chk($sformatf("row%0d ex_ready", i), 32'(ex_ready), 32'(vecs[i].e_exr));
      chk($sformatf("row%0d wren", i), 32'(rf_wren), 32'(vecs[i].e_wren));
      if (vecs[i].e_wren) begin
        chk($sformatf("row%0d waddr", i), 32'(rf_waddr), 32'(vecs[i].e_waddr));
        chk($sformatf("row%0d wdata", i), rf_wdata, vecs[i].e_wdata);
      end
      chk($sformatf("row%0d hit1", i), 32'(chk_hit1), 32'(vecs[i].e_hit1));
      chk($sformatf("row%0d data1", i), chk_data1, vecs[i].e_d1);
      chk($sformatf("row%0d hit2", i), 32'(chk_hit2), 32'(vecs[i].e_hit2));
      chk($sformatf("row%0d data2", i), chk_data2, vecs[i].e_d2);
      chk($sformatf("row%0d empty", i), 32'(empty), 32'(vecs[i].e_empty));
      chk($sformatf("row%0d full", i), 32'(full), 32'd0);
      step();
    end

    // Reset mid-operation with three entries queued.
    idle_inputs();
    ld_valid = 1'b1; ld_rd = 5'd10; ld_data = 32'hD10;
    ex_valid = 1'b1; ex_rd = 5'd11; ex_data = 32'hD11;
    step();
    ld_rd = 5'd12; ld_data = 32'hD12;
    ex_rd = 5'd13; ex_data = 32'hD13;
    step();
    idle_inputs();
    chk_addr1 = 5'd13; chk_addr2 = 5'd12;
    #1;
    chk("mid pre wren", 32'(rf_wren), 32'd1);
    chk("mid pre waddr", 32'(rf_waddr), 32'd11);
    chk("mid pre hit1", 32'(chk_hit1), 32'd1);
    chk("mid pre data1", chk_data1, 32'hD13);
    rst = 1'b0;
    #1;
    chk("mid rst wren", 32'(rf_wren), 32'd0);
    chk("mid rst empty", 32'(empty), 32'd1);
    chk("mid rst hit1", 32'(chk_hit1), 32'd0);
    chk("mid rst hit2", 32'(chk_hit2), 32'd0);
    step();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("stale wren%0d", k), 32'(rf_wren), 32'd0);
      chk($sformatf("stale empty%0d", k), 32'(empty), 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
